// File: rtl/alu_execute_unit_if.sv
// Issue/writeback bundle between the register bank and the ALU execute stage.
// master = register bank side, slave = execute unit.
interface alu_execute_unit_if #(
    parameter int XLEN = 32
);
    logic            op_valid;
    logic            op_imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            ready;
    logic [XLEN-1:0] alu_out;
    logic [4:0]      rd_out;
    logic            save_to_reg;
    logic            illegal;

    modport master (
        output op_valid, op_imm, funct3, funct7, imm, rs1_data, rs2_data, rd,
        input  ready, alu_out, rd_out, save_to_reg, illegal
    );

    modport slave (
        input  op_valid, op_imm, funct3, funct7, imm, rs1_data, rs2_data, rd,
        output ready, alu_out, rd_out, save_to_reg, illegal
    );
endinterface

// File: rtl/alu_execute_unit.sv
// RV32I execute stage; RV32M_EN adds the iterative 33-cycle mul/div FSM (otherwise M-ops are illegal).
// Base ops: 1 cycle, back-to-back; mul/div hold ready low until the DONE cycle, stalled op_valid is dropped.
module alu_execute_unit #(
    parameter int XLEN = 32
`ifdef RV32M_EN
    , parameter int MD_CYCLES = 32
`endif
) (
    input logic               stage_clk,
    input logic               reset,
    alu_execute_unit_if.slave io
);
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    logic [XLEN-1:0] op_a, op_b, base_result;
    logic [4:0]      shamt;
    logic            is_shift, base_ok, md_op, illegal_op, accept, unit_ready;

    assign op_a     = io.rs1_data;
    assign op_b     = io.op_imm ? io.imm : io.rs2_data;
    assign shamt    = op_b[4:0];
    assign is_shift = (io.funct3[1:0] == 2'b01);
    assign accept   = io.op_valid && unit_ready;
    assign io.ready = unit_ready;

    // OP-IMM only carries a real funct7 on shifts; elsewhere it is immediate bits.
    always_comb begin
        base_ok = 1'b0;
        md_op   = 1'b0;
        if (io.op_imm) begin
            base_ok = !is_shift || (io.funct7 == F7_BASE) || ((io.funct7 == F7_ALT) && io.funct3[2]);
        end else begin
            base_ok = (io.funct7 == F7_BASE) ||
                      ((io.funct7 == F7_ALT) && ((io.funct3 == 3'b000) || (io.funct3 == 3'b101)));
`ifdef RV32M_EN
            md_op   = (io.funct7 == F7_MD);
`endif
        end
    end
    assign illegal_op = !base_ok && !md_op;

    always_comb begin
        base_result = '0;
        case (io.funct3)
            3'b000: base_result = (!io.op_imm && io.funct7[5]) ? op_a - op_b : op_a + op_b;
            3'b001: base_result = op_a << shamt;
            3'b010: base_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011: base_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100: base_result = op_a ^ op_b;
            3'b101: base_result = io.funct7[5] ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
            3'b110: base_result = op_a | op_b;
            default: base_result = op_a & op_b;
        endcase
    end

`ifdef RV32M_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  md_cnt;
    logic [2*XLEN-1:0] md_acc, mul_prod;
    logic [XLEN-1:0]   md_b, md_dividend, md_result, md_quot, md_rem;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2:0]        md_f3;
    logic [4:0]        md_rd;
    logic              md_neg_a, md_neg_b, md_div0, md_last;
    logic              sgn_a, sgn_b, neg_a, neg_b;

    assign md_last = (md_cnt == CNT_W'(MD_CYCLES));

    always_ff @(posedge stage_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        unit_ready = 1'b0;
        case (state)
            IDLE, DONE: begin
                unit_ready = 1'b1;
                state_nxt  = IDLE;
                if (io.op_valid && md_op) state_nxt = io.funct3[2] ? DIV : MUL;
            end
            MUL, DIV: if (md_last) state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Signed operands: MUL/MULH/MULHSU(rs1), MUL/MULH(rs2), DIV/REM (both).
    assign sgn_a = io.funct3[2] ? !io.funct3[0] : (io.funct3[1:0] != 2'b11);
    assign sgn_b = io.funct3[2] ? !io.funct3[0] : !io.funct3[1];
    assign neg_a = sgn_a && io.rs1_data[XLEN-1];
    assign neg_b = sgn_b && io.rs2_data[XLEN-1];

    // md_acc: multiply = {partial high, multiplier shifting out}; divide = {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, md_acc[2*XLEN-1:XLEN]} + (md_acc[0] ? {1'b0, md_b} : '0);
    assign div_diff = md_acc[2*XLEN-1:XLEN-1] - {1'b0, md_b};
    assign mul_prod = (md_neg_a ^ md_neg_b) ? -md_acc : md_acc;
    assign md_quot  = md_acc[XLEN-1:0];
    assign md_rem   = md_acc[2*XLEN-1:XLEN];

    always_comb begin
        md_result = '0;
        if (!md_f3[2])     md_result = (md_f3[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
        else if (md_div0)  md_result = md_f3[1] ? md_dividend : '1;
        else if (md_f3[1]) md_result = md_neg_a ? -md_rem : md_rem;
        else               md_result = (md_neg_a ^ md_neg_b) ? -md_quot : md_quot;
    end
`else
    assign unit_ready = 1'b1;
`endif

    always_ff @(posedge stage_clk) begin
        if (reset) begin
            io.alu_out     <= '0;
            io.rd_out      <= '0;
            io.save_to_reg <= 1'b0;
            io.illegal     <= 1'b0;
`ifdef RV32M_EN
            md_cnt      <= '0;
            md_acc      <= '0;
            md_b        <= '0;
            md_dividend <= '0;
            md_f3       <= '0;
            md_rd       <= '0;
            md_neg_a    <= 1'b0;
            md_neg_b    <= 1'b0;
            md_div0     <= 1'b0;
`endif
        end else begin
            io.save_to_reg <= 1'b0;
            io.illegal     <= 1'b0;
            if (accept) begin
                if (illegal_op) begin
                    io.illegal <= 1'b1;
                end else if (!md_op) begin
                    io.alu_out     <= base_result;
                    io.rd_out      <= io.rd;
                    io.save_to_reg <= (io.rd != 5'd0);
                end
            end
`ifdef RV32M_EN
            if (accept && md_op) begin
                md_acc      <= {{XLEN{1'b0}}, (neg_a ? -io.rs1_data : io.rs1_data)};
                md_b        <= neg_b ? -io.rs2_data : io.rs2_data;
                md_dividend <= io.rs1_data;
                md_f3       <= io.funct3;
                md_rd       <= io.rd;
                md_neg_a    <= neg_a;
                md_neg_b    <= neg_b;
                md_div0     <= (io.rs2_data == '0);
                md_cnt      <= '0;
            end
            if ((state == MUL) || (state == DIV)) begin
                if (md_last) begin
                    io.alu_out     <= md_result;
                    io.rd_out      <= md_rd;
                    io.save_to_reg <= (md_rd != 5'd0);
                end else begin
                    md_cnt <= md_cnt + CNT_W'(1);
                    if (state == MUL)      md_acc <= {mul_sum, md_acc[XLEN-1:1]};
                    else if (!div_diff[XLEN]) md_acc <= {div_diff[XLEN-1:0], md_acc[XLEN-2:0], 1'b1};
                    else                   md_acc <= {md_acc[2*XLEN-2:0], 1'b0};
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed bench for alu_execute_unit; M-extension scenarios follow the RV32M_EN build setting.
module tb_alu_execute_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_execute_unit_if bus ();
    alu_execute_unit dut (.stage_clk(clk), .reset(reset), .io(bus));

    // Drives one op for exactly one posedge; returns #1 after that edge.
    task automatic issue(input logic imm_sel, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_imm   = imm_sel;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.rs1_data = a;
        bus.imm      = imm_sel ? b : ~b;
        bus.rs2_data = imm_sel ? ~b : b;
        bus.rd       = rd;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        n_tests++; if (bus.alu_out !== 32'd0) begin n_fail++; $display("FAIL reset_alu_out: got %h expected 0", bus.alu_out); end
        n_tests++; if (bus.rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd_out: got %0d expected 0", bus.rd_out); end
        n_tests++; if (bus.save_to_reg !== 1'b0) begin n_fail++; $display("FAIL reset_save: got %b expected 0", bus.save_to_reg); end
        n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", bus.illegal); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        issue(1'b0, 3'b000, 7'h00, 32'd5, 32'd7, 5'd3);
        n_tests++; if (bus.alu_out !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h expected %h", bus.alu_out, 32'd12); end
        n_tests++; if (bus.rd_out !== 5'd3) begin n_fail++; $display("FAIL add_rd: got %0d expected 3", bus.rd_out); end
        n_tests++; if (bus.save_to_reg !== 1'b1) begin n_fail++; $display("FAIL add_save: got %b expected 1", bus.save_to_reg); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.save_to_reg !== 1'b0) begin n_fail++; $display("FAIL add_save_pulse: got %b expected 0", bus.save_to_reg); end
    endtask

    // Issued back to back, one op per cycle.
    task automatic test_base_ops();
        logic        t_imm [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  t_f3  [11] = '{3'b000, 3'b101, 3'b011, 3'b010, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b010};
        logic [6:0]  t_f7  [11] = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
        logic [31:0] t_a   [11] = '{32'h0, 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h3, 32'hF0F0F0F0,
                                    32'h80000000, 32'h0F, 32'hFF0, 32'd10, 32'hFFFFFFFE};
        logic [31:0] t_b   [11] = '{32'h1, 32'h404, 32'hFFFFFFFF, 32'h1, 32'h21, 32'hFF00FF00,
                                    32'h4, 32'hF0, 32'h0FF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_exp [11] = '{32'hFFFFFFFF, 32'hF8000000, 32'h1, 32'h1, 32'h6, 32'h0FF00FF0,
                                    32'h08000000, 32'hFF, 32'hF0, 32'd9, 32'h1};
        for (int i = 0; i < 11; i++) begin
            issue(t_imm[i], t_f3[i], t_f7[i], t_a[i], t_b[i], 5'(i + 1));
            n_tests++; if (bus.alu_out !== t_exp[i]) begin n_fail++; $display("FAIL base_op%0d_result: got %h expected %h", i, bus.alu_out, t_exp[i]); end
            n_tests++; if (bus.rd_out !== 5'(i + 1) || bus.save_to_reg !== 1'b1) begin n_fail++; $display("FAIL base_op%0d_write: got rd %0d save %b expected rd %0d save 1", i, bus.rd_out, bus.save_to_reg, i + 1); end
            n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL base_op%0d_ready: got %b expected 1", i, bus.ready); end
        end
    endtask

    task automatic test_rd0_illegal();
        issue(1'b0, 3'b000, 7'h00, 32'd2, 32'd3, 5'd0);
        n_tests++; if (bus.alu_out !== 32'd5 || bus.rd_out !== 5'd0) begin n_fail++; $display("FAIL rd0_update: got %h/%0d expected 5/0", bus.alu_out, bus.rd_out); end
        n_tests++; if (bus.save_to_reg !== 1'b0) begin n_fail++; $display("FAIL rd0_save: got %b expected 0", bus.save_to_reg); end
        issue(1'b0, 3'b000, 7'h7F, 32'd9, 32'd9, 5'd7);
        n_tests++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_f7_pulse: got %b expected 1", bus.illegal); end
        n_tests++; if (bus.save_to_reg !== 1'b0) begin n_fail++; $display("FAIL illegal_f7_save: got %b expected 0", bus.save_to_reg); end
        n_tests++; if (bus.alu_out !== 32'd5 || bus.rd_out !== 5'd0) begin n_fail++; $display("FAIL illegal_f7_hold: got %h/%0d expected 5/0", bus.alu_out, bus.rd_out); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_one_cycle: got %b expected 0", bus.illegal); end
        issue(1'b0, 3'b111, 7'h20, 32'd1, 32'd1, 5'd7);
        n_tests++; if (bus.illegal !== 1'b1 || bus.save_to_reg !== 1'b0) begin n_fail++; $display("FAIL illegal_sub_on_and: got illegal %b save %b expected 1/0", bus.illegal, bus.save_to_reg); end
    endtask

`ifdef RV32M_EN
    // Issues one M-op and waits for its write strobe; optionally pokes op_valid during the stall.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit poke, output int lat, output bit rdy_seen);
        issue(1'b0, f3, 7'h01, a, b, rd);
        lat      = 0;
        rdy_seen = bus.ready;
        if (poke) begin
            bus.op_valid = 1'b1; bus.op_imm = 1'b0; bus.funct3 = 3'b000; bus.funct7 = 7'h00;
            bus.rs1_data = 32'd100; bus.rs2_data = 32'd1; bus.rd = 5'd9;
        end
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 25) bus.op_valid = 1'b0;
            if (bus.save_to_reg) break;
            if (bus.ready) rdy_seen = 1'b1;
        end
        bus.op_valid = 1'b0;
    endtask

    task automatic test_mul();
        int lat;
        bit rdy_seen;
        logic [2:0]  t_f3  [3] = '{3'b000, 3'b011, 3'b010};
        logic [31:0] t_a   [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_b   [3] = '{32'd3, 32'hFFFFFFFF, 32'd2};
        logic [31:0] t_exp [3] = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF};
        run_md(3'b001, 32'hFFFFFFFF, 32'd3, 5'd5, 1'b1, lat, rdy_seen);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL mulh_latency: got %0d expected 33", lat); end
        n_tests++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL mulh_stall_ready: got %b expected 0", rdy_seen); end
        n_tests++; if (bus.alu_out !== 32'hFFFFFFFF || bus.rd_out !== 5'd5) begin n_fail++; $display("FAIL mulh_result: got %h/%0d expected ffffffff/5", bus.alu_out, bus.rd_out); end
        n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL mulh_done_ready: got %b expected 1", bus.ready); end
        issue(1'b0, 3'b000, 7'h00, 32'd1, 32'd2, 5'd4);
        n_tests++; if (bus.alu_out !== 32'd3 || bus.save_to_reg !== 1'b1) begin n_fail++; $display("FAIL issue_in_done: got %h save %b expected 3 save 1", bus.alu_out, bus.save_to_reg); end
        for (int i = 0; i < 3; i++) begin
            run_md(t_f3[i], t_a[i], t_b[i], 5'd6, 1'b0, lat, rdy_seen);
            n_tests++; if (bus.alu_out !== t_exp[i] || lat !== 33) begin n_fail++; $display("FAIL mul%0d_result: got %h lat %0d expected %h lat 33", i, bus.alu_out, lat, t_exp[i]); end
        end
    endtask

    task automatic test_div();
        int lat;
        bit rdy_seen;
        logic [2:0]  t_f3  [8] = '{3'b100, 3'b110, 3'b100, 3'b101, 3'b111, 3'b110, 3'b100, 3'b111};
        logic [31:0] t_a   [8] = '{32'd7, 32'h80000000, 32'h80000000, 32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5};
        logic [31:0] t_b   [8] = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd2, 32'd2, 32'd0};
        logic [31:0] t_exp [8] = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'd14, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd5};
        for (int i = 0; i < 8; i++) begin
            run_md(t_f3[i], t_a[i], t_b[i], 5'd10, 1'b0, lat, rdy_seen);
            n_tests++; if (bus.alu_out !== t_exp[i] || lat !== 33) begin n_fail++; $display("FAIL div%0d_result: got %h lat %0d expected %h lat 33", i, bus.alu_out, lat, t_exp[i]); end
        end
    endtask

    task automatic test_md_reset();
        int saves = 0;
        issue(1'b0, 3'b101, 7'h01, 32'd100, 32'd7, 5'd8);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (bus.ready !== 1'b1 || bus.alu_out !== 32'd0) begin n_fail++; $display("FAIL md_reset_state: got ready %b alu_out %h expected 1/0", bus.ready, bus.alu_out); end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.save_to_reg) saves++;
        end
        n_tests++; if (saves !== 0) begin n_fail++; $display("FAIL md_reset_no_save: got %0d pulses expected 0", saves); end
    endtask
`else
    task automatic test_no_m();
        int low = 0;
        issue(1'b0, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd3, 5'd5);
        n_tests++; if (bus.illegal !== 1'b1 || bus.save_to_reg !== 1'b0) begin n_fail++; $display("FAIL no_m_mul: got illegal %b save %b expected 1/0", bus.illegal, bus.save_to_reg); end
        n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL no_m_ready: got %b expected 1", bus.ready); end
        issue(1'b0, 3'b100, 7'h01, 32'd7, 32'd2, 5'd6);
        n_tests++; if (bus.illegal !== 1'b1 || bus.rd_out === 5'd6) begin n_fail++; $display("FAIL no_m_div: got illegal %b rd_out %0d expected 1 and no write", bus.illegal, bus.rd_out); end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready !== 1'b1) low++;
        end
        n_tests++; if (low !== 0) begin n_fail++; $display("FAIL no_m_ready_drop: got %0d low cycles expected 0", low); end
    endtask
`endif

    initial begin
        bus.op_valid = 1'b0; bus.op_imm = 1'b0; bus.funct3 = '0; bus.funct7 = '0;
        bus.imm = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd = '0;
        test_reset();
        test_add();
        test_base_ops();
        test_rd0_illegal();
`ifdef RV32M_EN
        test_mul();
        test_div();
        test_md_reset();
`else
        test_no_m();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
